// File: rtl/tbd_pkg.sv
// Shared types for the target box detector: coordinate width and the box slot record.
package tbd_pkg;
  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   coord_ext_t;

  typedef struct packed {
    logic   valid;
    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;
  } box_t;

  // Zero-extend so +GAP / +1 comparisons cannot wrap.
  function automatic coord_ext_t ext(input coord_t c);
    return {1'b0, c};
  endfunction
endpackage

// File: rtl/run_extractor.sv
// Frame/line edge detection, pixel coordinates and horizontal foreground run capture.
module run_extractor
  import tbd_pkg::*;
#(
  parameter coord_t IMG_HDISP = 10'd640,
  parameter coord_t IMG_VDISP = 10'd480
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   vsync,
  input  logic   href,
  input  logic   clken,
  input  logic   pix_bit,
  output logic   frame_start,
  output logic   frame_end,
  output logic   run_vld,
  output coord_t run_start,
  output coord_t run_end,
  output coord_t run_y
);
  localparam coord_t ONE   = coord_t'(1);
  localparam coord_t X_MAX = IMG_HDISP - ONE;
  localparam coord_t Y_MAX = IMG_VDISP - ONE;

  logic   vsync_d, href_d, frame_act, run_open;
  coord_t x, y, open_start, open_end;
  logic   vsync_rise, vsync_fall, href_fall, pix, close_pix, close_line, close;

  assign vsync_rise = vsync && !vsync_d;
  assign vsync_fall = !vsync && vsync_d;
  assign href_fall  = !href && href_d;
  assign pix        = frame_act && vsync && href && clken;
  assign close_pix  = pix && !pix_bit && run_open;
  // A run still open at line end or frame end is closed at the last foreground x.
  assign close_line = frame_act && run_open && (href_fall || vsync_fall);
  assign close      = close_pix || close_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d     <= 1'b1;
      href_d      <= 1'b0;
      frame_act   <= 1'b0;
      run_open    <= 1'b0;
      x           <= '0;
      y           <= '0;
      open_start  <= '0;
      open_end    <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      run_vld     <= 1'b0;
      run_start   <= '0;
      run_end     <= '0;
      run_y       <= '0;
    end else begin
      vsync_d     <= vsync;
      href_d      <= href;
      frame_start <= vsync_rise;
      frame_end   <= vsync_fall && frame_act;
      run_vld     <= close;

      if (vsync_rise)      frame_act <= 1'b1;
      else if (vsync_fall) frame_act <= 1'b0;

      if (href_fall)                         x <= '0;
      else if (href && clken && x != X_MAX)  x <= x + ONE;

      if (vsync_rise)                     y <= '0;
      else if (href_fall && y != Y_MAX)   y <= y + ONE;

      if (close) begin
        run_start <= open_start;
        run_end   <= open_end;
        run_y     <= y;
      end

      if (vsync_rise || close) begin
        run_open <= 1'b0;
      end else if (pix && pix_bit) begin
        if (!run_open) begin
          run_open   <= 1'b1;
          open_start <= x;
        end
        open_end <= x;
      end
    end
  end
endmodule

// File: rtl/target_box_detector.sv
// Merges foreground runs into up to MAX_TARGET bounding boxes and publishes them at frame end.
module target_box_detector
  import tbd_pkg::*;
#(
  parameter logic [9:0] IMG_HDISP  = 10'd640,
  parameter logic [9:0] IMG_VDISP  = 10'd480,
  parameter int         MAX_TARGET = 8,
  parameter int         GAP        = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          per_frame_vsync,
  input  logic                          per_frame_href,
  input  logic                          per_frame_clken,
  input  logic                          per_img_Bit,
  output logic [MAX_TARGET*COORD_W-1:0] box_xmin,
  output logic [MAX_TARGET*COORD_W-1:0] box_xmax,
  output logic [MAX_TARGET*COORD_W-1:0] box_ymin,
  output logic [MAX_TARGET*COORD_W-1:0] box_ymax,
  output logic [MAX_TARGET-1:0]         box_mask,
  output logic                          box_overflow,
  output logic                          frame_done
);
  localparam coord_ext_t GAP_W = GAP[COORD_W:0];
  localparam coord_ext_t ONE_W = coord_ext_t'(1);

  logic   frame_start, frame_end, run_vld;
  coord_t run_start, run_end, run_y;

  run_extractor #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP)
  ) u_run (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .vsync       (per_frame_vsync),
    .href        (per_frame_href),
    .clken       (per_frame_clken),
    .pix_bit     (per_img_Bit),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .run_vld     (run_vld),
    .run_start   (run_start),
    .run_end     (run_end),
    .run_y       (run_y)
  );

  box_t [MAX_TARGET-1:0] slots, slots_nxt;
  logic [MAX_TARGET-1:0] match, hit_sel, free_sel;
  logic                  hit_found, free_found, ovf, ovf_nxt;

  for (genvar i = 0; i < MAX_TARGET; i++) begin : g_match
    assign match[i] = slots[i].valid
                   && (ext(run_start) <= ext(slots[i].xmax) + GAP_W)
                   && (ext(run_end) + GAP_W >= ext(slots[i].xmin))
                   && (ext(run_y) <= ext(slots[i].ymax) + ONE_W);
  end

  // Priority select: lowest matching slot and lowest free slot.
  always_comb begin
    hit_sel    = '0;
    free_sel   = '0;
    hit_found  = 1'b0;
    free_found = 1'b0;
    for (int i = 0; i < MAX_TARGET; i++) begin
      hit_sel[i]  = match[i] && !hit_found;
      hit_found   = hit_found || match[i];
      free_sel[i] = !slots[i].valid && !free_found;
      free_found  = free_found || !slots[i].valid;
    end
  end

  // Only the lowest match absorbs the run; other overlapping boxes stay separate.
  always_comb begin
    slots_nxt = slots;
    ovf_nxt   = ovf;
    if (run_vld) begin
      for (int i = 0; i < MAX_TARGET; i++) begin
        if (hit_found) begin
          if (hit_sel[i]) begin
            if (run_start < slots[i].xmin) slots_nxt[i].xmin = run_start;
            if (run_end > slots[i].xmax)   slots_nxt[i].xmax = run_end;
            slots_nxt[i].ymax = run_y;
          end
        end else if (free_sel[i]) begin
          slots_nxt[i] = '{valid: 1'b1, xmin: run_start, xmax: run_end,
                           ymin: run_y, ymax: run_y};
        end
      end
      if (!hit_found && !free_found) ovf_nxt = 1'b1;
    end
  end

  // At frame end the run committed this cycle is forwarded straight into the published boxes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slots        <= '0;
      ovf          <= 1'b0;
      box_xmin     <= '0;
      box_xmax     <= '0;
      box_ymin     <= '0;
      box_ymax     <= '0;
      box_mask     <= '0;
      box_overflow <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        for (int i = 0; i < MAX_TARGET; i++) begin
          box_xmin[i*COORD_W +: COORD_W] <= slots_nxt[i].xmin;
          box_xmax[i*COORD_W +: COORD_W] <= slots_nxt[i].xmax;
          box_ymin[i*COORD_W +: COORD_W] <= slots_nxt[i].ymin;
          box_ymax[i*COORD_W +: COORD_W] <= slots_nxt[i].ymax;
          box_mask[i]                    <= slots_nxt[i].valid;
        end
        box_overflow <= ovf_nxt;
      end
      if (frame_end || frame_start) begin
        slots <= '0;
        ovf   <= 1'b0;
      end else begin
        slots <= slots_nxt;
        ovf   <= ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_target_box_detector.sv
// Bench for target_box_detector: directed frame table, hand sequences and random frames vs a run/box model.
module tb_target_box_detector;
  localparam int MT  = 8;
  localparam int GAP = 2;
  localparam int CW  = 10;

  logic sys_clk = 1'b0, sys_rst_n = 1'b1;
  logic vs = 1'b0, hr = 1'b0, ce = 1'b0, bt = 1'b0;
  logic [MT*CW-1:0] box_xmin, box_xmax, box_ymin, box_ymax;
  logic [MT-1:0]    box_mask;
  logic             box_overflow, frame_done;

  target_box_detector #(
    .IMG_HDISP (10'd640),
    .IMG_VDISP (10'd480),
    .MAX_TARGET(MT),
    .GAP       (GAP)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .per_frame_vsync(vs),
    .per_frame_href (hr),
    .per_frame_clken(ce),
    .per_img_Bit    (bt),
    .box_xmin       (box_xmin),
    .box_xmax       (box_xmax),
    .box_ymin       (box_ymin),
    .box_ymax       (box_ymax),
    .box_mask       (box_mask),
    .box_overflow   (box_overflow),
    .frame_done     (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0, checks = 0, done_cnt = 0;
  always @(posedge sys_clk) if (frame_done) done_cnt <= done_cnt + 1;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Frame image and geometry
  bit img [64][640];
  int W, L, cut, gaps;

  // Model state
  int e_valid[MT], e_xmin[MT], e_xmax[MT], e_ymin[MT], e_ymax[MT];
  int e_ovf;

  typedef struct {
    int ax0, ax1, ay0, ay1;
    int bx0, bx1, by0, by1;
    int w, l, cut;
    int mask, ovf;
    int s0xmin, s0xmax, s0ymin, s0ymax;
    int s1xmin, s1xmax, s1ymin, s1ymax;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int fld(input logic [MT*CW-1:0] bus, input int i);
    return int'(bus[i*CW +: CW]);
  endfunction

  task automatic clear_img();
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 640; x++) img[y][x] = 1'b0;
  endtask

  task automatic add_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y][x] = 1'b1;
  endtask

  task automatic send_line(input int y, input int w);
    hr = 1'b1;
    for (int x = 0; x < w; x++) begin
      if (gaps != 0 && $urandom_range(0, 3) == 0) begin
        ce = 1'b0; bt = 1'($urandom);
        @(negedge sys_clk);
      end
      ce = 1'b1; bt = img[y][x];
      @(negedge sys_clk);
    end
    ce = 1'b0; bt = 1'b0;
  endtask

  task automatic end_line();
    ce = 1'b0; bt = 1'b0; hr = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic drive_frame();
    @(negedge sys_clk);
    vs = 1'b1; hr = 1'b0; ce = 1'b0; bt = 1'b0;
    repeat (3) @(negedge sys_clk);
    for (int y = 0; y < L; y++) begin
      if (cut != 0 && y == L - 1) begin
        send_line(y, cut);
        vs = 1'b0;             // frame ends with href still high and a run possibly open
        @(negedge sys_clk);
        end_line();
      end else begin
        send_line(y, W);
        end_line();
      end
    end
    vs = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    int ok = 0;
    for (int i = 0; i < 30 && ok == 0; i++) begin
      @(negedge sys_clk);
      if (done_cnt > start) ok = 1;
    end
    check({tag, " frame_done seen"}, ok, 1);
    repeat (3) @(negedge sys_clk);
    check({tag, " frame_done single pulse"}, done_cnt - start, 1);
  endtask

  task automatic model_apply(input int s, input int e, input int y);
    for (int i = 0; i < MT; i++)
      if (e_valid[i] != 0 && s <= e_xmax[i] + GAP && e + GAP >= e_xmin[i] && y <= e_ymax[i] + 1) begin
        if (s < e_xmin[i]) e_xmin[i] = s;
        if (e > e_xmax[i]) e_xmax[i] = e;
        e_ymax[i] = y;
        return;
      end
    for (int i = 0; i < MT; i++)
      if (e_valid[i] == 0) begin
        e_valid[i] = 1; e_xmin[i] = s; e_xmax[i] = e; e_ymin[i] = y; e_ymax[i] = y;
        return;
      end
    e_ovf = 1;
  endtask

  // Scan the image line by line, emit maximal 1-runs in order, merge into boxes.
  task automatic model_frame();
    e_ovf = 0;
    for (int i = 0; i < MT; i++) e_valid[i] = 0;
    for (int y = 0; y < L; y++) begin
      int w = (cut != 0 && y == L - 1) ? cut : W;
      int s = 0, e = 0, open = 0;
      for (int x = 0; x < w; x++) begin
        if (img[y][x]) begin
          if (open == 0) begin open = 1; s = x; end
          e = x;
        end else if (open != 0) begin
          model_apply(s, e, y);
          open = 0;
        end
      end
      if (open != 0) model_apply(s, e, y);
    end
  endtask

  task automatic cmp_model(input string tag);
    int m = 0;
    for (int i = 0; i < MT; i++) if (e_valid[i] != 0) m |= (1 << i);
    check({tag, " mask"}, int'(box_mask), m);
    check({tag, " overflow"}, int'(box_overflow), e_ovf);
    for (int i = 0; i < MT; i++)
      if (e_valid[i] != 0) begin
        check($sformatf("%s s%0d xmin", tag, i), fld(box_xmin, i), e_xmin[i]);
        check($sformatf("%s s%0d xmax", tag, i), fld(box_xmax, i), e_xmax[i]);
        check($sformatf("%s s%0d ymin", tag, i), fld(box_ymin, i), e_ymin[i]);
        check($sformatf("%s s%0d ymax", tag, i), fld(box_ymax, i), e_ymax[i]);
      end
  endtask

  initial begin
    int start;
    vecs[0] = '{100,109,50,54,  -1,0,0,0,       120,56,0,  1,0, 100,109,50,54, 0,0,0,0};
    vecs[1] = '{20,29,10,19,    300,309,10,19,  320,21,0,  3,0, 20,29,10,19,   300,309,10,19};
    vecs[2] = '{50,59,5,5,      61,70,6,6,      80,8,0,    1,0, 50,70,5,6,     0,0,0,0};
    vecs[3] = '{630,639,0,1,    5,9,3,3,        640,4,10,  3,0, 630,639,0,1,   5,9,3,3};

    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset mask", int'(box_mask), 0);
    check("reset overflow", int'(box_overflow), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset boxes zero", int'(|{box_xmin, box_xmax, box_ymin, box_ymax}), 0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Directed frame table
    gaps = 0;
    for (int k = 0; k < 4; k++) begin
      string tag = $sformatf("vec%0d", k);
      clear_img();
      add_rect(vecs[k].ax0, vecs[k].ax1, vecs[k].ay0, vecs[k].ay1);
      if (vecs[k].bx0 >= 0) add_rect(vecs[k].bx0, vecs[k].bx1, vecs[k].by0, vecs[k].by1);
      W = vecs[k].w; L = vecs[k].l; cut = vecs[k].cut;
      start = done_cnt;
      drive_frame();
      wait_done(tag, start);
      check({tag, " mask"}, int'(box_mask), vecs[k].mask);
      check({tag, " overflow"}, int'(box_overflow), vecs[k].ovf);
      check({tag, " s0 xmin"}, fld(box_xmin, 0), vecs[k].s0xmin);
      check({tag, " s0 xmax"}, fld(box_xmax, 0), vecs[k].s0xmax);
      check({tag, " s0 ymin"}, fld(box_ymin, 0), vecs[k].s0ymin);
      check({tag, " s0 ymax"}, fld(box_ymax, 0), vecs[k].s0ymax);
      if (vecs[k].mask[1]) begin
        check({tag, " s1 xmin"}, fld(box_xmin, 1), vecs[k].s1xmin);
        check({tag, " s1 xmax"}, fld(box_xmax, 1), vecs[k].s1xmax);
        check({tag, " s1 ymin"}, fld(box_ymin, 1), vecs[k].s1ymin);
        check({tag, " s1 ymax"}, fld(box_ymax, 1), vecs[k].s1ymax);
      end
    end

    // Reset asserted mid-frame with a run open; released while vsync is still high
    clear_img(); add_rect(10, 14, 2, 4);
    W = 20; L = 6; cut = 0;
    start = done_cnt;
    @(negedge sys_clk); vs = 1'b1;
    repeat (3) @(negedge sys_clk);
    send_line(0, 20); end_line();
    send_line(1, 20); end_line();
    send_line(2, 12);
    sys_rst_n = 1'b0; ce = 1'b0;
    @(negedge sys_clk);
    check("midrst mask", int'(box_mask), 0);
    check("midrst boxes zero", int'(|{box_xmin, box_xmax, box_ymin, box_ymax}), 0);
    sys_rst_n = 1'b1;
    end_line();
    send_line(3, 20); end_line();
    send_line(4, 20); end_line();
    vs = 1'b0;
    repeat (12) @(negedge sys_clk);
    check("midrst no frame_done", done_cnt - start, 0);
    check("midrst mask held", int'(box_mask), 0);
    check("midrst overflow held", int'(box_overflow), 0);
    start = done_cnt;
    drive_frame();
    wait_done("postrst", start);
    model_frame();
    cmp_model("postrst");
    check("postrst s0 xmin", fld(box_xmin, 0), 10);
    check("postrst s0 ymax", fld(box_ymax, 0), 4);

    // MAX_TARGET+1 isolated dots on row 0: the last one is dropped
    clear_img();
    for (int k = 0; k <= MT; k++) img[0][k*10] = 1'b1;
    W = 90; L = 1; cut = 0;
    start = done_cnt;
    drive_frame();
    wait_done("dots", start);
    check("dots mask", int'(box_mask), (1 << MT) - 1);
    check("dots overflow", int'(box_overflow), 1);
    for (int k = 0; k < MT; k++) begin
      check($sformatf("dots s%0d xmin", k), fld(box_xmin, k), k*10);
      check($sformatf("dots s%0d xmax", k), fld(box_xmax, k), k*10);
      check($sformatf("dots s%0d ymax", k), fld(box_ymax, k), 0);
    end

    // Random noise frames with clken gaps
    gaps = 1;
    for (int f = 0; f < 12; f++) begin
      clear_img();
      W = 48; L = 12;
      cut = ($urandom_range(0, 2) == 0) ? $urandom_range(20, 47) : 0;
      for (int y = 0; y < L; y++)
        for (int x = 0; x < W; x++)
          img[y][x] = ($urandom_range(0, 5) == 0);
      add_rect($urandom_range(0, 30), 40, $urandom_range(0, 5), $urandom_range(6, 11));
      start = done_cnt;
      drive_frame();
      wait_done($sformatf("rnd%0d", f), start);
      model_frame();
      cmp_model($sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/target_box_detector.md
# target_box_detector

Downstream of the 3x3 dilation stage in the multi-target detection path. Consumes the dilated 1-bit pixel stream, extracts horizontal foreground runs per line and merges them into up to MAX_TARGET bounding boxes per frame. At frame end it publishes all boxes, a valid mask and an overflow flag for the box overlay and the host readout.

## Interface
- IMG_HDISP, 10'd640: active pixels per line
- IMG_VDISP, 10'd480: active lines per frame
- MAX_TARGET, 8: box slots (1..16)
- GAP, 2: horizontal merge tolerance in pixels
- sys_clk  in  1  pixel clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- per_frame_vsync  in  1  high for the whole active frame
- per_frame_href  in  1  high during active line
- per_frame_clken  in  1  pixel qualifier
- per_img_Bit  in  1  dilated pixel, 1 = foreground
- box_xmin, box_xmax, box_ymin, box_ymax  out  MAX_TARGET*10 each  slot i at bits [10i+9:10i]
- box_mask  out  MAX_TARGET  slot i holds a box
- box_overflow  out  1  at least one run was dropped this frame
- frame_done  out  1  one-cycle pulse when outputs update

## Operation
- Edge detect: vsync_d, href_d registered; vsync_d resets to 1 so a frame in progress at reset release is ignored. Processing enabled (frame_act) from vsync rising to vsync falling.
- Coordinates: x (10 b) increments per clken while href=1, cleared on href falling; y (10 b) increments on href falling, cleared on vsync rising. No wrap inside a legal frame; x and y saturate at IMG_HDISP-1 / IMG_VDISP-1.
- Run capture: clken with bit=1 and no open run -> open, run_start=x. Run closes at clken with bit=0 (run_end=x-1) or href falling (run_end=last x). Close registers run_start, run_end, run_y and pulses run_vld for one cycle.
- Match on run_vld (all slots compared in parallel): slot i matches if valid_i, run_start <= xmax_i+GAP, run_end+GAP >= xmin_i, run_y <= ymax_i+1. Comparisons 11 b, no wrap.
- Lowest-index match: xmin=min, xmax=max, ymax=run_y (ymin unchanged). Other matches are not merged (known limitation).
- No match: allocate lowest free slot with xmin=run_start, xmax=run_end, ymin=ymax=run_y. No free slot: drop run, set ovf.
- Frame end (vsync falling): a run open at that point is closed as by href falling; pending run_vld commits first; then all slots copied to outputs, box_mask=valid, box_overflow=ovf, frame_done pulses; working slots and ovf clear in the same cycle.
- Vsync rising also clears working slots and ovf (defensive).

## Timing
- Reset: every output 0; working slots invalid; run closed; x=y=0.
- run_vld 1 cycle after the closing clken / href-falling sample; slot update 1 cycle after run_vld.
- frame_done asserted 2 cycles after the first cycle vsync samples low; outputs stable until the next frame_done.
- Minimum run spacing is 2 clken, so one merge per cycle is sufficient; no back-pressure.
- Reset mid-frame: all state cleared, no frame_done for that frame; detection resumes at next vsync rising.

## Structure
- Shared package tbd_pkg: COORD_W=10, box record typedef {valid, xmin, xmax, ymin, ymax}.
- One sub-module: run_extractor (edge detect, x/y counters, run capture, run_vld). Top holds slot array, match/allocate logic and output latch.

## Test plan
- Single 10x5 square at x=100..109, y=50..54 -> frame_done, box_mask=0x01, slot0 = (100,109,50,54), overflow=0.
- Two squares at x=20..29 and x=300..309, rows 10..19 -> mask=0x03, slot0 xmin=20, slot1 xmin=300.
- Runs x=50..59 row 5 and x=61..70 row 6 (gap 1 <= GAP) -> single box (50,70,5,6).
- MAX_TARGET+1 isolated dots on row 0 at x=0,10,20,... -> mask all ones, overflow=1, last dot absent.
- Run touching x=639 at line end and a run open at vsync falling -> both closed, xmax=639, correct ymax.
- Assert sys_rst_n low mid-frame, release with vsync high -> no frame_done until a full following frame; outputs 0 meanwhile.
